// File: rtl/i2c_rx_word_packer_pkg.sv
// ---------------------------------------------------------------------------
// i2c_rx_word_packer_pkg
//   Shared definitions for the I2C receive word packer.
//   - BYTE_W       : byte width of the I2C read-data stream
//   - pack_state_t : packer FSM states, encoded to match the i2c control FSM
//   - cnt_width()  : width of a counter that indexes n items (at least 1 bit)
// ---------------------------------------------------------------------------
package i2c_rx_word_packer_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } pack_state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2c_rx_word_packer_sync_fifo.sv
// ---------------------------------------------------------------------------
// i2c_rx_word_packer_sync_fifo
//   Single-clock FIFO holding completed sensor words.
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     push       : write push_data (ignored while full)
//     push_data  : word to store
//     pop        : drop the head entry (ignored while empty)
//     pop_data   : current head entry
//     full/empty : occupancy flags, derived from the level register
//     level      : occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module i2c_rx_word_packer_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_reg == LW'(DEPTH));
    assign empty   = (level_reg == '0);
    assign level   = level_reg;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Head is read straight from the array so a word written into an empty
    // FIFO is presented the very next cycle without a bypass path.
    assign pop_data = mem[rd_ptr_reg];

    // Storage has no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/i2c_rx_word_packer.sv
// ---------------------------------------------------------------------------
// i2c_rx_word_packer
//   Packs consecutive bytes from the I2C master read stream into
//   WORD_BYTES-wide words and queues them in a small FIFO for the consumer.
//   A partial word is discarded on i_start (new transaction) or i_nak.
//   Ports:
//     i_clk, i_rst   : clock, asynchronous active-high reset
//     i_start        : transaction start pulse; flushes a partial word
//     i_nak          : NAK from the master; aborts a partial word (wins over i_start)
//     i_byte_bits    : received byte
//     i_byte_valid   : byte valid
//     o_byte_ready   : packer can take a byte
//     o_word_bits    : FIFO head word
//     o_word_valid   : FIFO not empty
//     i_word_ready   : consumer pops the head
//     o_level        : FIFO occupancy
//     o_drop         : one-cycle pulse when a partial word was discarded
//     o_nak_err      : sticky NAK flag, cleared by i_start
// ---------------------------------------------------------------------------
module i2c_rx_word_packer
    import i2c_rx_word_packer_pkg::*;
#(
    parameter int DATA_DEPTH = BYTE_W,
    parameter int WORD_BYTES = 2,
    parameter int MSB_FIRST  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_start,
    input  logic                               i_nak,
    input  logic [DATA_DEPTH-1:0]              i_byte_bits,
    input  logic                               i_byte_valid,
    output logic                               o_byte_ready,
    output logic [DATA_DEPTH*WORD_BYTES-1:0]   o_word_bits,
    output logic                               o_word_valid,
    input  logic                               i_word_ready,
    output logic [$clog2(FIFO_DEPTH):0]        o_level,
    output logic                               o_drop,
    output logic                               o_nak_err
);

    localparam int WORD_W = DATA_DEPTH * WORD_BYTES;
    localparam int CNT_W  = cnt_width(WORD_BYTES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_BYTES - 1);

    pack_state_t       state_reg;
    logic [CNT_W-1:0]  byte_cnt_reg;
    logic [WORD_W-1:0] accum_reg;
    logic [WORD_W-1:0] accum_next;
    logic              drop_reg;
    logic              nak_err_reg;

    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  eff_cnt;

    // Only the final byte of a word needs FIFO space; earlier bytes just
    // land in the accumulator, so ready depends on registered state only.
    assign o_byte_ready = ~fifo_full | (byte_cnt_reg != LAST_CNT);
    assign accept       = i_byte_valid & o_byte_ready;
    assign o_word_valid = ~fifo_empty;
    assign pop          = o_word_valid & i_word_ready;
    assign o_drop       = drop_reg;
    assign o_nak_err    = nak_err_reg;

    // A byte arriving with i_start is byte 0 of the new word.
    assign eff_cnt = i_start ? '0 : byte_cnt_reg;

    // A byte arriving with i_nak is discarded, so it can never complete a word.
    assign push = accept & ~i_nak & (eff_cnt == LAST_CNT);

    always_comb begin
        accum_next = accum_reg;
        if (MSB_FIRST != 0) begin
            // Shift-in: after WORD_BYTES bytes every stale bit has left the top.
            accum_next = (accum_reg << DATA_DEPTH) | WORD_W'(i_byte_bits);
        end else begin
            accum_next[eff_cnt*DATA_DEPTH +: DATA_DEPTH] = i_byte_bits;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg    <= ST_IDLE;
            byte_cnt_reg <= '0;
            accum_reg    <= '0;
            drop_reg     <= 1'b0;
            nak_err_reg  <= 1'b0;
        end else begin
            drop_reg <= 1'b0;
            if (i_nak) begin
                state_reg    <= ST_IDLE;
                byte_cnt_reg <= '0;
                nak_err_reg  <= 1'b1;
                drop_reg     <= (state_reg == ST_ACCUM);
            end else begin
                if (i_start) begin
                    nak_err_reg <= 1'b0;
                    drop_reg    <= (state_reg == ST_ACCUM);
                end
                if (accept) begin
                    accum_reg <= accum_next;
                    if (eff_cnt == LAST_CNT) begin
                        state_reg    <= ST_IDLE;
                        byte_cnt_reg <= '0;
                    end else begin
                        state_reg    <= ST_ACCUM;
                        byte_cnt_reg <= eff_cnt + CNT_W'(1);
                    end
                end else if (i_start) begin
                    state_reg    <= ST_IDLE;
                    byte_cnt_reg <= '0;
                end
            end
        end
    end

    i2c_rx_word_packer_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (push),
        .push_data (accum_next),
        .pop       (pop),
        .pop_data  (o_word_bits),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (o_level)
    );

endmodule

// File: tb/tb_i2c_rx_word_packer.sv
module tb_i2c_rx_word_packer;

    localparam int FD = 4;
    localparam int WB = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_start = 1'b0;
    logic        i_nak = 1'b0;
    logic [7:0]  i_byte_bits = 8'h00;
    logic        i_byte_valid = 1'b0;
    logic        i_word_ready = 1'b0;

    logic        m_byte_ready, l_byte_ready;
    logic [15:0] m_word_bits, l_word_bits;
    logic        m_word_valid, l_word_valid;
    logic [2:0]  m_level, l_level;
    logic        m_drop, l_drop;
    logic        m_nak_err, l_nak_err;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0]  part[$];
    logic [15:0] qm[$];
    logic [15:0] ql[$];
    bit          exp_drop = 1'b0;
    bit          exp_nak = 1'b0;

    always #5 clk = ~clk;

    i2c_rx_word_packer #(.DATA_DEPTH(8), .WORD_BYTES(WB), .MSB_FIRST(1), .FIFO_DEPTH(FD)) m (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_nak(i_nak),
        .i_byte_bits(i_byte_bits), .i_byte_valid(i_byte_valid), .o_byte_ready(m_byte_ready),
        .o_word_bits(m_word_bits), .o_word_valid(m_word_valid), .i_word_ready(i_word_ready),
        .o_level(m_level), .o_drop(m_drop), .o_nak_err(m_nak_err)
    );

    i2c_rx_word_packer #(.DATA_DEPTH(8), .WORD_BYTES(WB), .MSB_FIRST(0), .FIFO_DEPTH(FD)) l (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_nak(i_nak),
        .i_byte_bits(i_byte_bits), .i_byte_valid(i_byte_valid), .o_byte_ready(l_byte_ready),
        .o_word_bits(l_word_bits), .o_word_valid(l_word_valid), .i_word_ready(i_word_ready),
        .o_level(l_level), .o_drop(l_drop), .o_nak_err(l_nak_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic bit model_ready();
        return !(qm.size() == FD && part.size() == WB - 1);
    endfunction

    task automatic model_reset();
        part.delete();
        qm.delete();
        ql.delete();
        exp_drop = 1'b0;
        exp_nak = 1'b0;
    endtask

    task automatic check_outputs();
        chk("ready_m", 32'(m_byte_ready), 32'(model_ready()));
        chk("ready_l", 32'(l_byte_ready), 32'(model_ready()));
        chk("valid_m", 32'(m_word_valid), 32'(qm.size() != 0));
        chk("valid_l", 32'(l_word_valid), 32'(ql.size() != 0));
        chk("level_m", 32'(m_level), 32'(qm.size()));
        chk("level_l", 32'(l_level), 32'(ql.size()));
        chk("drop_m", 32'(m_drop), 32'(exp_drop));
        chk("drop_l", 32'(l_drop), 32'(exp_drop));
        chk("nak_m", 32'(m_nak_err), 32'(exp_nak));
        chk("nak_l", 32'(l_nak_err), 32'(exp_nak));
        if (qm.size() != 0) begin
            chk("word_m", 32'(m_word_bits), 32'(qm[0]));
            chk("word_l", 32'(l_word_bits), 32'(ql[0]));
        end
    endtask

    // One clock cycle: drive at negedge, model the edge, check at next negedge.
    task automatic step(input bit v, input logic [7:0] b, input bit st, input bit nk,
                        input bit wr, output bit acc);
        bit          pop;
        logic [15:0] wm;
        logic [15:0] wl;
        i_byte_valid = v;
        i_byte_bits  = b;
        i_start      = st;
        i_nak        = nk;
        i_word_ready = wr;
        acc = v && model_ready();
        pop = wr && (qm.size() != 0);
        @(posedge clk);
        if (pop) begin
            void'(qm.pop_front());
            void'(ql.pop_front());
        end
        exp_drop = 1'b0;
        if (nk) begin
            exp_drop = (part.size() != 0);
            exp_nak  = 1'b1;
            part.delete();
        end else begin
            if (st) begin
                exp_drop = (part.size() != 0);
                exp_nak  = 1'b0;
                part.delete();
            end
            if (acc) part.push_back(b);
        end
        if (part.size() == WB) begin
            wm = 16'h0;
            wl = 16'h0;
            for (int k = 0; k < WB; k++) begin
                wm = (wm << 8) | 16'(part[k]);
                wl = wl | (16'(part[k]) << (8 * k));
            end
            qm.push_back(wm);
            ql.push_back(wl);
            part.delete();
            $display("word pushed msb_first=%h lsb_first=%h level=%0d", wm, wl, qm.size());
        end
        @(negedge clk);
        check_outputs();
    endtask

    typedef struct {
        bit          v;
        logic [7:0]  b;
        bit          st;
        bit          nk;
        bit          wr;
        bit          e_valid;
        logic [15:0] e_wm;
        logic [15:0] e_wl;
        int          e_level;
        bit          e_drop;
        bit          e_nak;
    } vec_t;

    vec_t        tbl[11];
    logic [15:0] exp_list[5];

    initial begin
        bit acc;
        bit sent9;
        int popped;

        tbl[0]  = '{1'b1, 8'hAB, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'hCD, 1'b0, 1'b0, 1'b0, 1'b1, 16'hABCD, 16'hCDAB, 1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1122, 16'h2211, 1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 8'h88, 1'b0, 1'b0, 1'b0, 1'b1, 16'h9988, 16'h8899, 1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b0};

        exp_list[0] = 16'h0001;
        exp_list[1] = 16'h0203;
        exp_list[2] = 16'h0405;
        exp_list[3] = 16'h0607;
        exp_list[4] = 16'h0809;

        // reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_ready", 32'(m_byte_ready), 32'd1);
        chk("rst_valid", 32'(m_word_valid), 32'd0);
        chk("rst_level", 32'(m_level), 32'd0);
        chk("rst_drop", 32'(m_drop), 32'd0);
        chk("rst_nak", 32'(m_nak_err), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // directed table: basic packing, NAK abort, start flush
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].v, tbl[i].b, tbl[i].st, tbl[i].nk, tbl[i].wr, acc);
            $display("vector %0d byte=%h start=%0d nak=%0d wr=%0d -> valid=%0d word=%h level=%0d drop=%0d nak_err=%0d",
                     i, tbl[i].b, tbl[i].st, tbl[i].nk, tbl[i].wr,
                     m_word_valid, m_word_bits, m_level, m_drop, m_nak_err);
            chk("tbl_valid", 32'(m_word_valid), 32'(tbl[i].e_valid));
            chk("tbl_level", 32'(m_level), 32'(tbl[i].e_level));
            chk("tbl_drop", 32'(m_drop), 32'(tbl[i].e_drop));
            chk("tbl_nak", 32'(m_nak_err), 32'(tbl[i].e_nak));
            if (tbl[i].e_valid) begin
                chk("tbl_word_m", 32'(m_word_bits), 32'(tbl[i].e_wm));
                chk("tbl_word_l", 32'(l_word_bits), 32'(tbl[i].e_wl));
            end
        end

        // FIFO fill with consumer stalled, then drain in order
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, acc);
        end
        chk("fill_level", 32'(m_level), 32'd4);
        chk("fill_ready", 32'(m_byte_ready), 32'd0);
        popped = 0;
        sent9 = 1'b0;
        for (int c = 0; c < 20 && popped < 5; c++) begin
            if (m_word_valid) begin
                chk("pop_order", 32'(m_word_bits), 32'(exp_list[popped]));
                $display("word popped %h", m_word_bits);
                popped++;
            end
            step(!sent9, 8'h09, 1'b0, 1'b0, 1'b1, acc);
            if (acc) sent9 = 1'b1;
        end
        chk("pop_count", 32'(popped), 32'd5);

        // asynchronous reset with 3 words queued and one partial byte
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0, acc);
        end
        chk("pre_rst_level", 32'(m_level), 32'd3);
        i_byte_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(m_word_valid), 32'd0);
        chk("arst_level", 32'(m_level), 32'd0);
        chk("arst_ready", 32'(m_byte_ready), 32'd1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'h21, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, acc);
        chk("post_rst_word", 32'(m_word_bits), 32'h2122);

        // randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 1) == 1, acc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
